instr_fetch_stage: RTL and testbench

Pipelined instruction-fetch stage for the DLX-style processor. It owns the instruction address register and issues word fetches to an instruction memory over a req/ack handshake, which tolerates zero-wait or multi-cycle memory. Each fetched word is held in a one-entry output buffer that feeds the decode stage over a valid/ready handshake. A taken branch or jump resolved downstream redirects the stage and squashes in-flight or buffered work.

---
 rtl/instr_fetch_stage_if.sv | 26 ++
 rtl/instr_fetch_stage.sv | 120 ++++++++++++
 tb/tb_instr_fetch_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port, redirect input
// from execute, and the valid/ready output toward decode.
//   master : the fetch stage (drives imem_req/addr and the id_* buffer outputs)
//   slave  : the environment (memory, execute redirect, decode consumer)
interface instr_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus8;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc_plus8,
    input  imem_ack, imem_data, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc_plus8,
    output imem_ack, imem_data, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage. Owns the PC, keeps at most one request
// outstanding to instruction memory (zero-wait or multi-cycle ack), and
// holds each fetched word in a one-entry buffer toward decode. A redirect
// from execute overrides everything: it empties the buffer, reloads the PC
// and, if a request is still in flight, lets it finish with its data dropped.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : instr_fetch_stage_if.master (imem_*, redirect*, id_*)
module instr_fetch_stage #(
  parameter logic [31:0] InitAddress = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_fetch_stage_if.master    bus
);

  typedef enum logic [1:0] {IDLE, BUSY, SQUASH} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc8_q, pc8_d;

  logic        can_issue;
  logic        req;
  logic [31:0] redir_pc;

  // Target is word-aligned; low bits from execute are ignored.
  assign redir_pc = bus.redirect_pc & ~32'h3;

  // A new fetch may only go out if its ack can land in an empty or
  // draining buffer, which keeps one request outstanding at most.
  assign can_issue = !valid_q || bus.id_ready;

  always_comb begin
    req = 1'b0;
    case (state_q)
      IDLE:    req = can_issue && !bus.redirect;
      default: req = 1'b1;  // address must stay held until the ack
    endcase
    if (reset) req = 1'b0;
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = (state_q == IDLE) ? pc_q : fetch_addr_q;
  assign bus.id_valid    = valid_q;
  assign bus.id_instr    = instr_q;
  assign bus.id_pc_plus8 = pc8_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc8_d        = pc8_q;

    if (valid_q && bus.id_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.redirect) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
        end else if (req) begin
          fetch_addr_d = pc_q;
          if (bus.imem_ack) begin
            valid_d = 1'b1;
            instr_d = bus.imem_data;
            pc8_d   = pc_q + 32'd8;
            pc_d    = pc_q + 32'd4;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.redirect) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
          state_d = bus.imem_ack ? IDLE : SQUASH;
        end else if (bus.imem_ack) begin
          valid_d = 1'b1;
          instr_d = bus.imem_data;
          pc8_d   = fetch_addr_q + 32'd8;
          pc_d    = fetch_addr_q + 32'd4;
          state_d = IDLE;
        end
      end
      default: begin  // SQUASH: wait out the stale request, drop its data
        if (bus.redirect) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
        end
        if (bus.imem_ack) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= InitAddress;
      fetch_addr_q <= 32'h0;
      valid_q      <= 1'b0;
      instr_q      <= 32'h0;
      pc8_q        <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc8_q        <= pc8_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_stage_if bus ();

  instr_fetch_stage #(.InitAddress(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: ack after 'lat' wait cycles; data tags the address.
  int unsigned lat = 0;
  int unsigned wcnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             wcnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else                                   wcnt <= 0;
  end
  assign bus.imem_ack  = bus.imem_req && (wcnt >= lat);
  assign bus.imem_data = {16'hC0DE, bus.imem_addr[15:0]};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc8);
    exp_t e;
    e.instr = instr;
    e.pc8   = pc8;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every instruction consumed by decode must match the next
  // expected entry; anything extra is an error.
  always @(negedge clk) begin
    if (!reset && bus.id_valid && bus.id_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_extra: got instr %h pc8 %h expected nothing", bus.id_instr, bus.id_pc_plus8);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", bus.id_instr, e.instr);
        chk("sb_pc8", bus.id_pc_plus8, e.pc8);
      end
    end
  end

  initial begin
    bus.id_ready    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    #1 reset = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("rst_instr", bus.id_instr, 32'h0);
    chk("rst_pc8", bus.id_pc_plus8, 32'h0);

    // Zero-wait streaming then backpressure
    push(32'hC0DE_0000, 32'h8);
    push(32'hC0DE_0004, 32'hC);
    push(32'hC0DE_0008, 32'h10);
    step(); reset = 1'b0;                                   // c0
    @(negedge clk); chk("c0_req", {31'b0, bus.imem_req}, 32'h1);
                    chk("c0_addr", bus.imem_addr, 32'h0);
    step(); @(negedge clk); chk("c1_addr", bus.imem_addr, 32'h4);
    step(); @(negedge clk); chk("c2_addr", bus.imem_addr, 32'h8);
    step(); bus.id_ready = 1'b0;                            // c3..c5 stalled
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      @(negedge clk);
      chk("bp_req", {31'b0, bus.imem_req}, 32'h0);
      chk("bp_instr", bus.id_instr, 32'hC0DE_0008);
    end
    step(); bus.id_ready = 1'b1;                            // c6
    @(negedge clk); chk("bp_resume_req", {31'b0, bus.imem_req}, 32'h1);
                    chk("bp_resume_addr", bus.imem_addr, 32'hC);
    step(); reset = 1'b1;
    @(negedge clk); chk("rst_async_valid", {31'b0, bus.id_valid}, 32'h0);
    step();

    // Redirect during 3-cycle ack latency
    push(32'hC0DE_0000, 32'h8);
    push(32'hC0DE_0004, 32'hC);
    push(32'hC0DE_0100, 32'h108);
    step(); reset = 1'b0;                                   // d0
    @(negedge clk); chk("d0_addr", bus.imem_addr, 32'h0);
    step(); @(negedge clk); chk("d1_addr", bus.imem_addr, 32'h4);
    step(); lat = 3;                                        // d2
    @(negedge clk); chk("d2_addr", bus.imem_addr, 32'h8);
    step(); bus.redirect = 1'b1; bus.redirect_pc = 32'h100; // d3
    @(negedge clk); chk("sq_req_d3", {31'b0, bus.imem_req}, 32'h1);
                    chk("sq_addr_d3", bus.imem_addr, 32'h8);
    step(); bus.redirect = 1'b0;                            // d4
    @(negedge clk); chk("sq_addr_d4", bus.imem_addr, 32'h8);
                    chk("sq_valid_d4", {31'b0, bus.id_valid}, 32'h0);
    step();                                                 // d5: ack arrives
    @(negedge clk); chk("sq_ack_d5", {31'b0, bus.imem_ack}, 32'h1);
                    chk("sq_addr_d5", bus.imem_addr, 32'h8);
    step(); lat = 0;                                        // d6
    @(negedge clk); chk("sq_valid_d6", {31'b0, bus.id_valid}, 32'h0);
                    chk("redir_addr", bus.imem_addr, 32'h100);

    // Redirect coincident with ack
    step(); lat = 1;                                        // d7
    @(negedge clk); chk("d7_addr", bus.imem_addr, 32'h104);
    step(); bus.redirect = 1'b1; bus.redirect_pc = 32'h200; // d8
    @(negedge clk); chk("co_ack", {31'b0, bus.imem_ack}, 32'h1);
                    chk("co_addr", bus.imem_addr, 32'h104);
    step(); bus.redirect = 1'b0; lat = 0;                   // d9
    @(negedge clk); chk("co_valid", {31'b0, bus.id_valid}, 32'h0);
                    chk("co_next_addr", bus.imem_addr, 32'h200);

    // Redirect with full buffer and no ready, to a misaligned wrap target
    step(); bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF; bus.id_ready = 1'b0; // d10
    @(negedge clk); chk("rd_req", {31'b0, bus.imem_req}, 32'h0);
                    chk("rd_buf_instr", bus.id_instr, 32'hC0DE_0200);
                    chk("rd_buf_pc8", bus.id_pc_plus8, 32'h208);
    push(32'hC0DE_FFFC, 32'h0000_0004);
    push(32'hC0DE_0000, 32'h8);
    step(); bus.redirect = 1'b0; bus.id_ready = 1'b1;       // d11
    @(negedge clk); chk("rd_valid", {31'b0, bus.id_valid}, 32'h0);
                    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    step(); @(negedge clk); chk("wrap_next_addr", bus.imem_addr, 32'h0); // d12

    // Reset asserted mid-SQUASH
    step(); lat = 3;                                        // d13
    @(negedge clk); chk("d13_addr", bus.imem_addr, 32'h4);
    step(); bus.redirect = 1'b1; bus.redirect_pc = 32'h300; // d14
    step(); bus.redirect = 1'b0;                            // d15
    @(negedge clk); chk("ms_req", {31'b0, bus.imem_req}, 32'h1);
                    chk("ms_addr", bus.imem_addr, 32'h4);
    step(); reset = 1'b1;                                   // d16
    @(negedge clk); chk("ms_rst_req", {31'b0, bus.imem_req}, 32'h0);
                    chk("ms_rst_valid", {31'b0, bus.id_valid}, 32'h0);
    push(32'hC0DE_0000, 32'h8);
    step(); reset = 1'b0; lat = 0;                          // d17
    @(negedge clk); chk("ms_rel_req", {31'b0, bus.imem_req}, 32'h1);
                    chk("ms_rel_addr", bus.imem_addr, 32'h0);
    step();                                                 // d18: monitor pops
    step(); reset = 1'b1;
    repeat (3) step();
    chk("sb_drained", sb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
